// File: rtl/memory_layer_controller.sv
// Learning-step sequencer for the memory-layer datapath: load, empty check, nearest-two scan,
// threshold test, then node insert or winner update plus connection. Outputs are registered per state.
module memory_layer_controller #(
  parameter int MEM_RD_LAT = 1,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       min2_valid,
  input  logic [1:0] comparator_c,
  output logic       busy,
  output logic       done,
  output logic       ld_upcounter,
  output logic       en_upcounter,
  output logic       en_node_counter,
  output logic       en_connection,
  output logic       en_2min,
  output logic       learning_done,
  output logic       X_c,
  output logic       C_c,
  output logic       W_c,
  output logic       T_c,
  output logic       M_c,
  output logic       RD_WR_c,
  output logic [1:0] mux1_sel,
  output logic [1:0] mux2_sel,
  output logic [1:0] mux3_sel,
  output logic [1:0] mux4_sel,
  output logic [1:0] mux5_sel,
  output logic [1:0] mux6_sel,
  output logic [1:0] demux_sel
);

  typedef enum logic [3:0] {
    IDLE, LOAD, CHK_EMPTY, SCAN_RD, SCAN_WAIT, SCAN_ACC, SCAN_CHK, THR_RD,
    THR_CMP, INSERT, UPD_W1, RD_W2, UPD_W2, CONNECT, DONE
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ld_upcounter;
    logic       en_upcounter;
    logic       en_node_counter;
    logic       en_connection;
    logic       en_2min;
    logic       learning_done;
    logic       x_c;
    logic       c_c;
    logic       w_c;
    logic       t_c;
    logic       m_c;
    logic       rd_wr;
    logic [1:0] mux1_sel;
    logic [1:0] mux2_sel;
    logic [1:0] mux3_sel;
    logic [1:0] mux4_sel;
    logic [1:0] mux5_sel;
    logic [1:0] mux6_sel;
    logic [1:0] demux_sel;
  } ctrl_t;

  localparam logic [1:0] CMP_LT = 2'b00;
  localparam logic [1:0] CMP_EQ = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  // Hold-state exit points: r_lat is 0 on the first cycle spent in a state.
  localparam logic [1:0] C_RD_LAST   = 2'(MEM_RD_LAT - 1);
  localparam logic [1:0] C_WAIT_LAST = 2'((MEM_RD_LAT > 1) ? (MEM_RD_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] C_WDOG_MAX = '1;

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [1:0]       r_lat;
  logic [CNT_W-1:0] r_wdog;
  state_t           w_nxt;

  function automatic state_t f_next(input state_t s, input logic [1:0] lat,
                                    input logic [CNT_W-1:0] wdog, input logic strt,
                                    input logic m2v, input logic [1:0] cmp);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:      n = strt ? LOAD : IDLE;
      LOAD:      n = CHK_EMPTY;
      CHK_EMPTY: n = (cmp == CMP_EQ) ? INSERT : SCAN_RD;
      SCAN_RD:   n = (MEM_RD_LAT > 1) ? SCAN_WAIT : SCAN_ACC;
      SCAN_WAIT: n = (lat == C_WAIT_LAST) ? SCAN_ACC : SCAN_WAIT;
      SCAN_ACC:  n = SCAN_CHK;
      // Overrun (A>B) ends the scan like equality; runaway scans abort without writing.
      SCAN_CHK: begin
        if (cmp == CMP_EQ || cmp == CMP_GT) n = THR_RD;
        else if (wdog == C_WDOG_MAX)        n = DONE;
        else                                n = SCAN_RD;
      end
      THR_RD:    n = (lat == C_RD_LAST) ? THR_CMP : THR_RD;
      THR_CMP:   n = (cmp == CMP_LT) ? INSERT : UPD_W1;
      INSERT:    n = DONE;
      UPD_W1:    n = m2v ? RD_W2 : DONE;
      RD_W2:     n = (lat == C_RD_LAST) ? UPD_W2 : RD_W2;
      UPD_W2:    n = CONNECT;
      CONNECT:   n = DONE;
      DONE:      n = IDLE;
      default:   n = IDLE;
    endcase
    return n;
  endfunction

  function automatic ctrl_t f_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    c.busy = (s != IDLE) && (s != DONE);
    case (s)
      LOAD: c.ld_upcounter = 1'b1;
      CHK_EMPTY, SCAN_CHK: begin
        c.mux5_sel = 2'd1;
        c.mux6_sel = 2'd1;
      end
      SCAN_RD, SCAN_WAIT: begin
        c.mux1_sel = 2'd1;
        c.w_c      = 1'b1;
      end
      SCAN_ACC: begin
        c.en_2min      = 1'b1;
        c.en_upcounter = 1'b1;
      end
      THR_RD: begin
        c.mux1_sel  = 2'd2;
        c.t_c       = 1'b1;
        c.m_c       = 1'b1;
        c.w_c       = 1'b1;
        c.demux_sel = 2'd1;
      end
      THR_CMP: begin
        c.mux5_sel = 2'd2;
        c.mux6_sel = 2'd2;
      end
      INSERT: begin
        c.x_c             = 1'b1;
        c.w_c             = 1'b1;
        c.c_c             = 1'b1;
        c.t_c             = 1'b1;
        c.m_c             = 1'b1;
        c.rd_wr           = 1'b1;
        c.en_node_counter = 1'b1;
      end
      UPD_W1: begin
        c.mux1_sel = 2'd2;
        c.mux2_sel = 2'd1;
        c.w_c      = 1'b1;
        c.t_c      = 1'b1;
        c.m_c      = 1'b1;
        c.rd_wr    = 1'b1;
      end
      RD_W2: begin
        c.mux1_sel  = 2'd3;
        c.w_c       = 1'b1;
        c.demux_sel = 2'd2;
      end
      UPD_W2: begin
        c.mux1_sel = 2'd3;
        c.mux2_sel = 2'd2;
        c.w_c      = 1'b1;
        c.rd_wr    = 1'b1;
      end
      CONNECT: c.en_connection = 1'b1;
      DONE: begin
        c.done          = 1'b1;
        c.learning_done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign w_nxt = f_next(r_state, r_lat, r_wdog, start, min2_valid, comparator_c);

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ctrl  <= '0;
      r_lat   <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_nxt;
      r_ctrl  <= f_ctrl(w_nxt);
      r_lat   <= (w_nxt == r_state) ? r_lat + 2'd1 : 2'd0;
      if (r_state == LOAD)
        r_wdog <= '0;
      else if (r_state == SCAN_ACC && r_wdog != C_WDOG_MAX)
        r_wdog <= r_wdog + 1'b1;
    end
  end

  assign busy            = r_ctrl.busy;
  assign done            = r_ctrl.done;
  assign ld_upcounter    = r_ctrl.ld_upcounter;
  assign en_upcounter    = r_ctrl.en_upcounter;
  assign en_node_counter = r_ctrl.en_node_counter;
  assign en_connection   = r_ctrl.en_connection;
  assign en_2min         = r_ctrl.en_2min;
  assign learning_done   = r_ctrl.learning_done;
  assign X_c             = r_ctrl.x_c;
  assign C_c             = r_ctrl.c_c;
  assign W_c             = r_ctrl.w_c;
  assign T_c             = r_ctrl.t_c;
  assign M_c             = r_ctrl.m_c;
  assign RD_WR_c         = r_ctrl.rd_wr;
  assign mux1_sel        = r_ctrl.mux1_sel;
  assign mux2_sel        = r_ctrl.mux2_sel;
  assign mux3_sel        = r_ctrl.mux3_sel;
  assign mux4_sel        = r_ctrl.mux4_sel;
  assign mux5_sel        = r_ctrl.mux5_sel;
  assign mux6_sel        = r_ctrl.mux6_sel;
  assign demux_sel       = r_ctrl.demux_sel;

endmodule

// File: tb/tb_memory_layer_controller.sv
// Scoreboard bench: two controllers (read latency 1 and 3) driven by a small datapath stand-in;
// per-step expectations are queued at start and checked when each controller pulses done.
module tb_memory_layer_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, min2_valid;
  int         node_count;
  logic [1:0] thr_res;

  logic       busy_w[2], done_w[2], ldu_w[2], enu_w[2], ennode_w[2], enconn_w[2];
  logic       en2min_w[2], ldone_w[2], xc_w[2], cc_w[2], wc_w[2], tc_w[2], mc_w[2], rdwr_w[2];
  logic [1:0] mux1_w[2], mux2_w[2], mux3_w[2], mux4_w[2], mux5_w[2], mux6_w[2], demux_w[2];
  logic [1:0] cmp_w[2];
  int         upc[2];

  memory_layer_controller #(.MEM_RD_LAT(1), .CNT_W(8)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .min2_valid(min2_valid), .comparator_c(cmp_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .ld_upcounter(ldu_w[0]), .en_upcounter(enu_w[0]),
    .en_node_counter(ennode_w[0]), .en_connection(enconn_w[0]), .en_2min(en2min_w[0]),
    .learning_done(ldone_w[0]), .X_c(xc_w[0]), .C_c(cc_w[0]), .W_c(wc_w[0]), .T_c(tc_w[0]),
    .M_c(mc_w[0]), .RD_WR_c(rdwr_w[0]), .mux1_sel(mux1_w[0]), .mux2_sel(mux2_w[0]),
    .mux3_sel(mux3_w[0]), .mux4_sel(mux4_w[0]), .mux5_sel(mux5_w[0]), .mux6_sel(mux6_w[0]),
    .demux_sel(demux_w[0])
  );

  memory_layer_controller #(.MEM_RD_LAT(3), .CNT_W(8)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start), .min2_valid(min2_valid), .comparator_c(cmp_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .ld_upcounter(ldu_w[1]), .en_upcounter(enu_w[1]),
    .en_node_counter(ennode_w[1]), .en_connection(enconn_w[1]), .en_2min(en2min_w[1]),
    .learning_done(ldone_w[1]), .X_c(xc_w[1]), .C_c(cc_w[1]), .W_c(wc_w[1]), .T_c(tc_w[1]),
    .M_c(mc_w[1]), .RD_WR_c(rdwr_w[1]), .mux1_sel(mux1_w[1]), .mux2_sel(mux2_w[1]),
    .mux3_sel(mux3_w[1]), .mux4_sel(mux4_w[1]), .mux5_sel(mux5_w[1]), .mux6_sel(mux6_w[1]),
    .demux_sel(demux_w[1])
  );

  // Datapath stand-in: upcounter plus comparator (A/B chosen by mux5/mux6).
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ldu_w[i])      upc[i] <= 0;
      else if (enu_w[i]) upc[i] <= upc[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cmp_w[i] = 2'b11;
      if (mux5_w[i] == 2'd1 && mux6_w[i] == 2'd1)
        cmp_w[i] = (upc[i] < node_count) ? 2'b00 : ((upc[i] == node_count) ? 2'b01 : 2'b10);
      else if (mux5_w[i] == 2'd2 && mux6_w[i] == 2'd2)
        cmp_w[i] = thr_res;
    end
  end

  typedef struct packed {
    int n2min; int nwr; int nins; int nconn; int nscanrd; int nw2rd; int lat;
  } exp_t;

  typedef struct packed {
    bit active; int cyc; int n2min; int nwr; int nins; int nconn; int nscanrd; int nw2rd; int nbusy;
  } acc_t;

  exp_t q_l1[$];
  exp_t q_l3[$];
  acc_t acc[2];
  int   checks = 0, failures = 0;
  int   to_req = 0, to_done = 0;
  bit   end_req = 1'b0, end_done = 1'b0;
  logic rst_q = 1'b1;

  always @(posedge clk) rst_q <= rst_n;

  function automatic logic [27:0] ovec(input int i);
    return {busy_w[i], done_w[i], ldu_w[i], enu_w[i], ennode_w[i], enconn_w[i], en2min_w[i],
            ldone_w[i], xc_w[i], cc_w[i], wc_w[i], tc_w[i], mc_w[i], rdwr_w[i], mux1_w[i],
            mux2_w[i], mux3_w[i], mux4_w[i], mux5_w[i], mux6_w[i], demux_w[i]};
  endfunction

  task automatic cmp(input string name, input int d, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut_lat%0d actual=%0d required=%0d", name, (d == 0) ? 1 : 3, act, req);
    end
  endtask

  task automatic finish_step(input int i);
    exp_t e;
    if ((i == 0 && q_l1.size() == 0) || (i == 1 && q_l3.size() == 0)) begin
      cmp("unexpected_done", i, 1, 0);
      return;
    end
    e = (i == 0) ? q_l1.pop_front() : q_l3.pop_front();
    cmp("latency",       i, acc[i].cyc,     e.lat);
    cmp("en_2min_count", i, acc[i].n2min,   e.n2min);
    cmp("write_cycles",  i, acc[i].nwr,     e.nwr);
    cmp("insert_cycles", i, acc[i].nins,    e.nins);
    cmp("connections",   i, acc[i].nconn,   e.nconn);
    cmp("scan_rd_cycles",i, acc[i].nscanrd, e.nscanrd);
    cmp("w2_rd_cycles",  i, acc[i].nw2rd,   e.nw2rd);
    cmp("busy_cycles",   i, acc[i].nbusy,   e.lat - 1);
    cmp("learning_done", i, int'(ldone_w[i]), 1);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (to_done < to_req) begin
        to_done++;
        cmp("step_timeout", 0, 1, 0);
      end
      if (rst_q === 1'b0) begin
        for (int i = 0; i < 2; i++) begin
          cmp("reset_outputs", i, int'(ovec(i)), 0);
          acc[i] = '0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (acc[i].active) begin
            acc[i].cyc++;
            if (en2min_w[i]) acc[i].n2min++;
            if (rdwr_w[i]) acc[i].nwr++;
            if (ennode_w[i] && rdwr_w[i] && xc_w[i] && cc_w[i] && mux1_w[i] == 2'd0) acc[i].nins++;
            if (enconn_w[i]) acc[i].nconn++;
            if (wc_w[i] && !rdwr_w[i] && mux1_w[i] == 2'd1) acc[i].nscanrd++;
            if (wc_w[i] && !rdwr_w[i] && mux1_w[i] == 2'd3 && demux_w[i] == 2'd2) acc[i].nw2rd++;
            if (busy_w[i]) acc[i].nbusy++;
            if (done_w[i]) begin
              finish_step(i);
              acc[i].active = 1'b0;
            end
          end else begin
            cmp("idle_quiet", i, int'(ovec(i)), 0);
            if (start && !busy_w[i]) begin
              acc[i] = '0;
              acc[i].active = 1'b1;
            end
          end
        end
      end
      if (end_req && !end_done) begin
        cmp("pending_l1", 0, q_l1.size(), 0);
        cmp("pending_l3", 1, q_l3.size(), 0);
        end_done = 1'b1;
      end
    end
  end

  task automatic run_step(input int n, input logic [1:0] thr, input logic m2,
                          input exp_t e1, input exp_t e3, input bit spur);
    int k;
    node_count = n;
    thr_res    = thr;
    min2_valid = m2;
    q_l1.push_back(e1);
    q_l3.push_back(e3);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (spur) begin
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    k = 0;
    while ((acc[0].active || acc[1].active) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (acc[0].active || acc[1].active) to_req++;
    repeat (3) @(posedge clk);
  endtask

  //                fields: n2min nwr nins nconn nscanrd nw2rd lat
  initial begin
    rst_n = 1'b0; start = 1'b0; min2_valid = 1'b0; node_count = 0; thr_res = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Empty class: straight to insert.
    run_step(0, 2'b11, 1'b0, '{0, 1, 1, 0, 0, 0, 4}, '{0, 1, 1, 0, 0, 0, 4}, 1'b0);
    // Abort mid-scan with a 3-cycle reset; the step is never completed.
    node_count = 5; thr_res = 2'b00; min2_valid = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    // 3-node scan, threshold below ED -> insert; extra start while busy.
    run_step(3, 2'b00, 1'b0, '{3, 1, 1, 0, 3, 0, 15}, '{3, 1, 1, 0, 9, 0, 23}, 1'b1);
    // 2-node scan, update both winners and connect.
    run_step(2, 2'b10, 1'b1, '{2, 2, 0, 1, 2, 1, 15}, '{2, 2, 0, 1, 6, 3, 23}, 1'b0);
    // Single node, equality at threshold, no second winner.
    run_step(1, 2'b01, 1'b0, '{1, 1, 0, 0, 1, 0, 9}, '{1, 1, 0, 0, 3, 0, 13}, 1'b0);
    // Scan never terminates: watchdog ends the step after 255 iterations with no write.
    run_step(300, 2'b00, 1'b0, '{255, 0, 0, 0, 255, 0, 768}, '{255, 0, 0, 0, 765, 0, 1278}, 1'b0);
    end_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
